// File: rtl/cpu_bus_responder_if.sv
// rtl/cpu_bus_responder_if.sv - CPU bus and backing-memory port bundle for cpu_bus_responder
// slave is the responder's view; master is the CPU core plus backing memory.
interface cpu_bus_responder_if #(
   parameter int WFIFO_DEPTH = 4
);
   localparam int CNT_W = $clog2(WFIFO_DEPTH) + 1;

   logic [7:0]       cpuAddrHigh;
   logic [7:0]       cpuAddrLow;
   logic             cpuReadNotWrite;
   logic [7:0]       cpuDataOut;
   logic             cpuSync;
   logic [7:0]       cpuDataIn;
   logic             cpuReady;

   logic             memReq;
   logic             memWe;
   logic [15:0]      memAddr;
   logic [7:0]       memWdata;
   logic [7:0]       memRdata;
   logic             memAck;

   logic [15:0]      lastFetchAddr;
   logic [CNT_W-1:0] wfifoCount;
   logic             overflowErr;

   modport slave (
      input  cpuAddrHigh, cpuAddrLow, cpuReadNotWrite, cpuDataOut, cpuSync,
      input  memRdata, memAck,
      output cpuDataIn, cpuReady,
      output memReq, memWe, memAddr, memWdata,
      output lastFetchAddr, wfifoCount, overflowErr
   );

   modport master (
      output cpuAddrHigh, cpuAddrLow, cpuReadNotWrite, cpuDataOut, cpuSync,
      output memRdata, memAck,
      input  cpuDataIn, cpuReady,
      input  memReq, memWe, memAddr, memWdata,
      input  lastFetchAddr, wfifoCount, overflowErr
   );
endinterface

// File: rtl/cpu_bus_responder.sv
// rtl/cpu_bus_responder.sv - 8227 CPU bus responder bridging to a req/ack memory port
// Reads stall the core via cpuReady; writes are posted into a FIFO and drained in the background.
module cpu_bus_responder #(
   parameter int WFIFO_DEPTH = 4
) (
   input  logic clk,
   input  logic nrst,
   cpu_bus_responder_if.slave bus
);
   localparam int PTR_W = $clog2(WFIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WR_REQ  = 2'd1;
   localparam logic [1:0] S_RD_REQ  = 2'd2;
   localparam logic [1:0] S_RD_DONE = 2'd3;

   logic [15:0]      cpu_addr;
   logic             cpu_write;
   logic             cpu_ready;

   logic [1:0]       state_q, state_d;
   logic [15:0]      rd_addr_q, rd_addr_d;
   logic [7:0]       data_q, data_d;
   logic [15:0]      last_fetch_q, last_fetch_d;
   logic             overflow_q, overflow_d;

   logic             mem_req_q, mem_req_d;
   logic             mem_we_q, mem_we_d;
   logic [15:0]      mem_addr_q, mem_addr_d;
   logic [7:0]       mem_wdata_q, mem_wdata_d;

   logic [23:0]      fifo_q [WFIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;
   logic [23:0]      fifo_head;

   assign cpu_addr   = {bus.cpuAddrHigh, bus.cpuAddrLow};
   assign cpu_write  = ~bus.cpuReadNotWrite;

   assign fifo_full  = (count_q == CNT_W'(WFIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign fifo_head  = fifo_q[rd_ptr_q];

   // A full FIFO drops the write even if the head retires this same cycle.
   assign push       = cpu_write & ~fifo_full;
   assign pop        = (state_q == S_WR_REQ) & bus.memAck;

   assign cpu_ready  = (state_q == S_RD_DONE) & bus.cpuReadNotWrite & (cpu_addr == rd_addr_q);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (cpu_write && fifo_full) begin
         overflow_d = 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      rd_addr_d    = rd_addr_q;
      data_d       = data_q;
      last_fetch_d = last_fetch_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      case (state_q)
         S_IDLE: begin
            // Draining first keeps a read from overtaking an earlier posted write.
            if (!fifo_empty) begin
               state_d     = S_WR_REQ;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = fifo_head[23:8];
               mem_wdata_d = fifo_head[7:0];
            end else if (bus.cpuReadNotWrite) begin
               state_d    = S_RD_REQ;
               rd_addr_d  = cpu_addr;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = cpu_addr;
            end
         end
         S_WR_REQ: begin
            if (bus.memAck) begin
               state_d   = S_IDLE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
            end
         end
         S_RD_REQ: begin
            if (bus.memAck) begin
               state_d   = S_RD_DONE;
               data_d    = bus.memRdata;
               mem_req_d = 1'b0;
            end
         end
         S_RD_DONE: begin
            // A moved address falls back to IDLE, which reissues the read.
            if (cpu_ready && bus.cpuSync) begin
               last_fetch_d = cpu_addr;
            end
            state_d = S_IDLE;
         end
         default: begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= S_IDLE;
         rd_addr_q    <= '0;
         data_q       <= '0;
         last_fetch_q <= '0;
         overflow_q   <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         rd_addr_q    <= rd_addr_d;
         data_q       <= data_d;
         last_fetch_q <= last_fetch_d;
         overflow_q   <= overflow_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

   // Entry storage is only ever read behind the occupancy count, so it needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= {cpu_addr, bus.cpuDataOut};
      end
   end

   assign bus.cpuDataIn     = data_q;
   assign bus.cpuReady      = cpu_ready;
   assign bus.memReq        = mem_req_q;
   assign bus.memWe         = mem_we_q;
   assign bus.memAddr       = mem_addr_q;
   assign bus.memWdata      = mem_wdata_q;
   assign bus.lastFetchAddr = last_fetch_q;
   assign bus.wfifoCount    = count_q;
   assign bus.overflowErr   = overflow_q;
endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb/tb_cpu_bus_responder.sv - self-checking bench for cpu_bus_responder
// CPU-visible memory model plus posted-write scoreboard, with directed scenarios.
module tb_cpu_bus_responder;
   localparam int DEPTH = 4;

   logic clk  = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   cpu_bus_responder_if #(.WFIFO_DEPTH(DEPTH)) bus ();
   cpu_bus_responder #(.WFIFO_DEPTH(DEPTH)) dut (.clk(clk), .nrst(nrst), .bus(bus));

   int checks = 0;
   int errors = 0;

   logic [7:0] bmem [65536];
   logic [7:0] vmem [65536];

   logic ack_tied  = 1'b0;
   logic ack_never = 1'b0;
   int   ack_delay = 0;
   int   wait_cnt  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Backing memory: ack after ack_delay waiting cycles; writes commit on their ack.
   always begin
      @(posedge clk);
      #1;
      if (ack_tied) begin
         bus.memAck = 1'b1;
      end else if (bus.memReq && !ack_never) begin
         if (wait_cnt >= ack_delay) begin
            bus.memAck = 1'b1;
            wait_cnt   = 0;
         end else begin
            bus.memAck = 1'b0;
            wait_cnt++;
         end
      end else begin
         bus.memAck = 1'b0;
         wait_cnt   = 0;
      end
      bus.memRdata = bmem[bus.memAddr];
      if (bus.memAck && bus.memReq && bus.memWe) bmem[bus.memAddr] = bus.memWdata;
   end

   int          cyc = 0;
   int          mcnt = 0;
   logic        movf = 1'b0;
   logic [15:0] mlfa = '0;
   logic [23:0] wq [$];
   int          wack_cyc [$];
   int          rd_req_cyc = 0;
   int          peak = 0;
   logic        p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
   logic [15:0] p_addr = '0;
   logic [7:0]  p_wd = '0;

   always @(negedge clk) begin
      logic [15:0] ca;
      logic [23:0] e;
      int          cnt_now;
      cyc++;
      ca = {bus.cpuAddrHigh, bus.cpuAddrLow};
      if (!nrst) begin
         chk("rst_memReq", 32'(bus.memReq), 0);
         chk("rst_memWe", 32'(bus.memWe), 0);
         chk("rst_memAddr", 32'(bus.memAddr), 0);
         chk("rst_memWdata", 32'(bus.memWdata), 0);
         chk("rst_cpuDataIn", 32'(bus.cpuDataIn), 0);
         chk("rst_cpuReady", 32'(bus.cpuReady), 0);
         chk("rst_lastFetch", 32'(bus.lastFetchAddr), 0);
         chk("rst_count", 32'(bus.wfifoCount), 0);
         chk("rst_overflow", 32'(bus.overflowErr), 0);
         mcnt = 0;
         movf = 1'b0;
         mlfa = '0;
         wq.delete();
         vmem = bmem;
         p_req = 1'b0;
         p_ack = 1'b0;
      end else begin
         chk("count", 32'(bus.wfifoCount), 32'(mcnt));
         chk("overflow", 32'(bus.overflowErr), 32'(movf));
         chk("lastFetch", 32'(bus.lastFetchAddr), 32'(mlfa));
         if (bus.cpuReady) begin
            chk("ready_on_read", 32'(bus.cpuReadNotWrite), 1);
            chk("read_data", 32'(bus.cpuDataIn), 32'(vmem[ca]));
         end
         if (p_req && p_ack) chk("req_drop_after_ack", 32'(bus.memReq), 0);
         if (p_req && !p_ack && bus.memReq) begin
            chk("addr_stable", 32'(bus.memAddr), 32'(p_addr));
            chk("we_stable", 32'(bus.memWe), 32'(p_we));
            if (p_we) chk("wdata_stable", 32'(bus.memWdata), 32'(p_wd));
         end
         if (bus.memReq && !bus.memWe && !p_req) rd_req_cyc = cyc;
         cnt_now = mcnt;
         if (bus.memReq && bus.memAck && bus.memWe) begin
            if (wq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL write_order: unexpected write 0x%0h<-0x%0h, none posted", bus.memAddr, bus.memWdata);
            end else begin
               e = wq.pop_front();
               chk("write_order", 32'({bus.memAddr, bus.memWdata}), 32'(e));
            end
            wack_cyc.push_back(cyc);
            mcnt--;
         end
         if (bus.cpuReady && bus.cpuSync) mlfa = ca;
         if (!bus.cpuReadNotWrite) begin
            if (cnt_now == DEPTH) begin
               movf = 1'b1;
            end else begin
               wq.push_back({ca, bus.cpuDataOut});
               vmem[ca] = bus.cpuDataOut;
               mcnt++;
            end
         end
         if (mcnt > peak) peak = mcnt;
         p_req  = bus.memReq;
         p_ack  = bus.memAck;
         p_we   = bus.memWe;
         p_addr = bus.memAddr;
         p_wd   = bus.memWdata;
      end
   end

   task automatic drive_read(input logic [15:0] a, input logic sync);
      bus.cpuAddrHigh     = a[15:8];
      bus.cpuAddrLow      = a[7:0];
      bus.cpuReadNotWrite = 1'b1;
      bus.cpuDataOut      = 8'h00;
      bus.cpuSync         = sync;
   endtask

   task automatic cpu_read(input logic [15:0] a, input logic sync, input logic rel,
                           output int stalls, output logic [7:0] d);
      logic got;
      got    = 1'b0;
      stalls = 0;
      d      = 8'h00;
      @(posedge clk);
      #1;
      if (rel) nrst = 1'b1;
      drive_read(a, sync);
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (bus.cpuReady) begin
            d   = bus.cpuDataIn;
            got = 1'b1;
            break;
         end
         stalls++;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL read_timeout: addr 0x%0h got no cpuReady, required within 60 cycles", a);
      end
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] wd);
      @(posedge clk);
      #1;
      bus.cpuAddrHigh     = a[15:8];
      bus.cpuAddrLow      = a[7:0];
      bus.cpuReadNotWrite = 1'b0;
      bus.cpuDataOut      = wd;
      bus.cpuSync         = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion before 200000");
      $fatal(1);
   end

   initial begin
      int         st;
      logic [7:0] d;
      for (int i = 0; i < 65536; i++) bmem[i] = 8'(i * 37 + 11);
      bmem[16'h0010] = 8'h5A;
      bmem[16'h1234] = 8'hA5;
      bmem[16'h0200] = 8'h00;
      bmem[16'hC000] = 8'hEA;
      bmem[16'hC001] = 8'h4C;
      vmem = bmem;
      bus.memAck   = 1'b0;
      bus.memRdata = 8'h00;
      drive_read(16'h0000, 1'b0);

      repeat (3) @(negedge clk);
      chk("init_ready", 32'(bus.cpuReady), 0);
      chk("init_count", 32'(bus.wfifoCount), 0);

      cpu_read(16'h0010, 1'b0, 1'b1, st, d);
      chk("first_read_stalls", 32'(st), 2);
      chk("first_read_data", 32'(d), 32'h5A);

      // Reset in the middle of a read request with memAck tied high.
      ack_tied = 1'b1;
      @(posedge clk);
      #1;
      drive_read(16'h1234, 1'b0);
      @(posedge clk);
      #3;
      chk("pre_reset_req", 32'(bus.memReq), 1);
      nrst = 1'b0;
      #1;
      chk("mid_reset_memReq", 32'(bus.memReq), 0);
      chk("mid_reset_ready", 32'(bus.cpuReady), 0);
      chk("mid_reset_dataIn", 32'(bus.cpuDataIn), 0);
      repeat (2) @(negedge clk);
      cpu_read(16'h1234, 1'b0, 1'b1, st, d);
      chk("post_reset_stalls", 32'(st), 2);
      chk("post_reset_data", 32'(d), 32'hA5);
      ack_tied = 1'b0;

      // memAck delayed by three cycles.
      ack_delay = 3;
      cpu_read(16'h1234, 1'b0, 1'b0, st, d);
      chk("delayed_stalls", 32'(st), 5);
      chk("delayed_data", 32'(d), 32'hA5);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("ready_one_cycle", 32'(bus.cpuReady), 0);
      ack_delay = 0;
      cpu_read(16'h1234, 1'b0, 1'b0, st, d);

      // Three back-to-back posted writes, then a read that waits for the drain.
      peak = 0;
      wack_cyc.delete();
      cpu_write(16'h01FD, 8'h12);
      cpu_write(16'h01FC, 8'h34);
      cpu_write(16'h01FB, 8'h56);
      cpu_read(16'h0300, 1'b0, 1'b0, st, d);
      chk("drain_read_data", 32'(d), 32'h0B);
      chk("wack_count", 32'(wack_cyc.size()), 3);
      if (wack_cyc.size() == 3) begin
         chk("wack_gap1", 32'(wack_cyc[1] - wack_cyc[0]), 2);
         chk("wack_gap2", 32'(wack_cyc[2] - wack_cyc[1]), 2);
      end
      chk("peak_le_3", 32'(peak <= 3), 1);
      chk("mem_01FD", 32'(bmem[16'h01FD]), 32'h12);
      chk("mem_01FB", 32'(bmem[16'h01FB]), 32'h56);
      chk("no_overflow", 32'(bus.overflowErr), 0);

      // Read-after-write to the same address.
      cpu_write(16'h0200, 8'h77);
      cpu_read(16'h0200, 1'b0, 1'b0, st, d);
      chk("raw_data", 32'(d), 32'h77);
      chk("raw_stalls", 32'(st), 4);
      if (wack_cyc.size() > 0) chk("raw_order", 32'(rd_req_cyc > wack_cyc[wack_cyc.size()-1]), 1);

      // Overflow with memory stalled.
      ack_never = 1'b1;
      for (int i = 0; i < 5; i++) cpu_write(16'h0400 + 16'(i), 8'h90 + 8'(i));
      @(posedge clk);
      #1;
      drive_read(16'h0404, 1'b0);
      @(negedge clk);
      chk("full_count", 32'(bus.wfifoCount), 4);
      chk("overflow_set", 32'(bus.overflowErr), 1);
      ack_never = 1'b0;
      cpu_read(16'h0404, 1'b0, 1'b0, st, d);
      chk("dropped_write_data", 32'(d), 32'h9F);
      chk("mem_0403", 32'(bmem[16'h0403]), 32'h93);
      chk("overflow_sticky", 32'(bus.overflowErr), 1);
      chk("drained_count", 32'(bus.wfifoCount), 0);
      @(posedge clk);
      #1;
      nrst = 1'b0;
      repeat (2) @(negedge clk);
      chk("overflow_cleared", 32'(bus.overflowErr), 0);

      // Opcode fetch tracking.
      cpu_read(16'hC000, 1'b1, 1'b1, st, d);
      chk("fetch_data", 32'(d), 32'hEA);
      cpu_read(16'hC001, 1'b0, 1'b0, st, d);
      chk("fetch_lfa", 32'(bus.lastFetchAddr), 32'hC000);
      chk("nonfetch_data", 32'(d), 32'h4C);
      @(posedge clk);
      #1;
      drive_read(16'h0010, 1'b0);
      @(negedge clk);
      chk("nonfetch_lfa", 32'(bus.lastFetchAddr), 32'hC000);

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
